// File: rtl/conv_result_drain_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_result_drain_if
// Control, accumulator-input and activation-output stream signals of
// conv_result_drain, grouped for connection between producer and drain.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface conv_result_drain_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic             start_i;
  logic             relu_en_i;
  logic [4:0]       shift_i;
  logic [15:0]      bias_i;
  logic             acc_valid_i;
  logic [ACC_W-1:0] acc_data_i;
  logic             acc_ready_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] out_data_o;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;
  logic             overflow_o;

  // Side that drives frame control, sums and output back-pressure
  modport master (
    output start_i, relu_en_i, shift_i, bias_i, acc_valid_i, acc_data_i, out_ready_i,
    input  acc_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, overflow_o
  );

  // The drain block itself
  modport slave (
    input  start_i, relu_en_i, shift_i, bias_i, acc_valid_i, acc_data_i, out_ready_i,
    output acc_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/conv_result_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_result_drain
// Converts finished accumulator window sums into 8-bit activations:
// bias add, optional ReLU, round-half-up right shift, saturation, then a
// small FWFT FIFO onto a valid/ready stream with a frame-last flag.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module conv_result_drain #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int NUM_OUT = 676
) (
  input  logic clk,
  input  logic rst_n,
  conv_result_drain_if.slave bus
);

  localparam int CNT_W  = $clog2(NUM_OUT + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int S1_W   = ACC_W + 1;
  // One extra bit so the rounding offset can never wrap the widest sum
  localparam int RND_W  = ACC_W + 2;
  localparam int USED_W = FCNT_W + 1;

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic                    cfg_relu;
  logic [4:0]              cfg_shift;
  logic [15:0]             cfg_bias;
  logic [CNT_W-1:0]        in_cnt;
  logic                    overflow;

  logic                    s1_valid, s1_last;
  logic signed [S1_W-1:0]  s1_data;
  logic                    s2_valid, s2_last;
  logic [OUT_W-1:0]        s2_data;

  logic [OUT_W-1:0]        mem_data [DEPTH];
  logic                    mem_last [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]       fifo_count;

  logic                    acc_ready, busy, done;
  logic                    accept, in_last, push, pop, fifo_empty;
  logic [USED_W-1:0]       used;
  logic signed [S1_W-1:0]  relu_val;
  logic signed [RND_W-1:0] rnd_val, shifted;
  logic [OUT_W-1:0]        sat_val;

  // Slots already spoken for: FIFO contents plus everything still in the pipe
  assign used       = USED_W'(fifo_count) + USED_W'(s1_valid) + USED_W'(s2_valid);
  assign accept     = bus.acc_valid_i & acc_ready;
  assign in_last    = (in_cnt == CNT_W'(NUM_OUT - 1));
  assign fifo_empty = (fifo_count == '0);
  assign push       = s2_valid;
  assign pop        = ~fifo_empty & bus.out_ready_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nx  = state;
    acc_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_nx = ST_RUN;
      end
      ST_RUN: begin
        acc_ready = (used < USED_W'(DEPTH));
        if (accept && in_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && mem_last[rd_ptr]) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Frame configuration, input counter and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_relu  <= 1'b0;
      cfg_shift <= '0;
      cfg_bias  <= '0;
      in_cnt    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start_i) begin
        cfg_relu  <= bus.relu_en_i;
        cfg_shift <= bus.shift_i;
        cfg_bias  <= bus.bias_i;
        in_cnt    <= '0;
        overflow  <= 1'b0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        // A sum is lost if it arrives without credit in RUN, or at all once draining
        if (bus.acc_valid_i &&
            ((state == ST_RUN && !acc_ready) || state == ST_DRAIN || state == ST_DONE))
          overflow <= 1'b1;
      end
    end
  end

  // Stage-2 arithmetic: ReLU, round-half-up shift, saturate
  always_comb begin
    relu_val = s1_data;
    if (cfg_relu && s1_data < 0) relu_val = '0;
    rnd_val = {relu_val[S1_W-1], relu_val};
    if (cfg_shift != 5'd0)
      rnd_val = rnd_val + (RND_W'(1) << (cfg_shift - 5'd1));
    shifted = rnd_val >>> cfg_shift;
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
  end

  // Two-stage processing pipeline; the last flag rides along with its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= in_last;
        s1_data <= {bus.acc_data_i[ACC_W-1], bus.acc_data_i}
                   + {{(S1_W-16){cfg_bias[15]}}, cfg_bias};
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_data <= sat_val;
      end
    end
  end

  // FIFO storage; contents are only visible while the count says valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s2_data;
      mem_last[wr_ptr] <= s2_last;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.acc_ready_o = acc_ready;
  assign bus.out_valid_o = ~fifo_empty;
  assign bus.out_data_o  = fifo_empty ? '0 : mem_data[rd_ptr];
  assign bus.out_last_o  = ~fifo_empty & mem_last[rd_ptr];
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.overflow_o  = overflow;

endmodule
`default_nettype wire
